alu_serial_responder: RTL and testbench
=======================================

Name: alu_serial_responder

Overview:
Serial-protocol ALU responder: the device end of the ALU serial link driven by the testbench BFM. Deserializes 11-bit packets from sin, assembles operands B and A, checks the command CRC4 and opcode, and computes the 32-bit result. It then serializes either a result frame or an error frame back on sout. It replaces the black-box ALU DUT for bench bring-up and acts as the golden protocol peer.

Parameters:
RSP_DELAY, 2, idle clocks between sampling the CMD stop bit and driving the first response start bit (legal 1..15)
N_DATA, 8, DATA packets required before a CMD packet

Ports:
clk  input  1  system clock; all sampling on posedge
rst_n  input  1  asynchronous active-low reset
sin  input  1  serial request line, idle high
sout  output  1  serial response line, idle high

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Packet format, both directions: start(0), type(0=DATA, 1=CMD), 8 payload bits MSB first, stop(1). 11 bits, one bit per clk.
- Reset, asserted at any time including mid-frame:
  - sout=1, FSM to RX_IDLE.
  - Bit counter, data-packet counter, operand shift register and CRC state all cleared.
- RX: in RX_IDLE, sin==0 sampled marks the start bit. The next 10 samples are type, payload, stop.
- Stop bit sampled 0: framing error. Discard the packet, counters unchanged, return to RX_IDLE.
- DATA packet: shift payload into a 64-bit register {B,A}; first byte is B[31:24], eighth byte is A[7:0]. Data counter increments, saturating at 15.
- CMD packet: payload = {1'b0, op[2:0], crc[3:0]}. Go to CHECK.
- CHECK (1 clk), priority ERR_DATA > ERR_CRC > ERR_OP:
  - ERR_DATA: data counter != N_DATA.
  - ERR_CRC: crc != CRC4({B,A,1'b1,op}). CRC4 polynomial x^4+x+1, init 0, 68 bits MSB first.
  - ERR_OP: op not in {AND=000, OR=001, ADD=100, SUB=101}.
- CHECK always clears the data counter.
- Arithmetic:
  - AND: C=B&A. OR: C=B|A. ADD: C=B+A. SUB: C=B-A.
  - Flags {carry, overflow, zero, negative}.
  - carry: ADD bit-32 carry out; SUB borrow (B<A unsigned).
  - overflow: signed overflow; 0 for AND/OR.
  - zero: C==0. negative: C[31].
- WAIT: sout=1 for RSP_DELAY clks counted from the CHECK cycle. Then TX_BITS.
- Result frame, sent back-to-back with no inter-packet gap:
  - 4 DATA packets C[31:24]..C[7:0].
  - Then CMD payload {1'b0, flags[3:0], crc3[2:0]}. crc3 = CRC3({C, 1'b0, flags}), polynomial x^3+x+1, init 0, 37 bits MSB first.
- Error frame:
  - Single CMD packet, payload {1'b1, err[5:0], parity}.
  - err = {d,c,o,d,c,o}; exactly one of d/c/o is set, per priority.
  - parity makes the 8-bit payload even-parity.
- sout changes only on posedge; one bit per clk. After the stop bit, return to RX_IDLE with sout=1.
- sin is ignored during CHECK/WAIT/TX_BITS. Packets arriving then are lost; the bench must not overlap.
- States: RX_IDLE -> RX_BITS -> (RX_IDLE on DATA or framing error | CHECK on CMD) -> WAIT -> TX_BITS -> RX_IDLE.
- Latency: first response start bit appears RSP_DELAY+1 clks after the CMD stop bit is sampled.
- Result frame = 55 clks; error frame = 11 clks.

Test Plan:
- Reset mid-frame: assert rst_n=0 during the 5th DATA packet, release, then send a valid ADD A=2 B=3 -> sout stays 1 through reset; response C=0x00000005, flags=0000; no residue from the aborted frame.
- ADD A=0xFFFFFFFF B=0x00000001, correct CRC -> 4 DATA bytes 00 00 00 00; CMD flags=1010 with crc3 matching the model; first start bit exactly RSP_DELAY+1 clks after the CMD stop bit.
- SUB B=5 A=7 -> C=0xFFFFFFFE, flags=1001. Also AND/OR of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 (flags 0000) and 0xFFF0FFF0 (flags 0001).
- Valid frame with the CMD crc field inverted -> single CMD packet, payload 0xA5.
- op=110 with correct CRC -> payload 0x93. Repeat with op=010 -> payload 0x93.
- Only 6 DATA packets, then CMD -> payload 0xC9. Repeat with 9 DATA packets -> 0xC9. A following valid frame is processed normally.
- Packet with stop bit forced 0 inside an otherwise valid frame -> packet dropped; CMD then sees 7 DATA packets -> 0xC9.

Source files
------------

// File: rtl/alu_serial_responder.sv
// alu_serial_responder
//   Device end of the ALU serial link. Receives 11-bit packets on sin
//   (start, type, 8 payload bits MSB first, stop), collects eight DATA bytes
//   into {B,A}, validates the CMD packet (data count, CRC4, opcode) and
//   serializes either a 5-packet result frame or a 1-packet error frame on sout.
//
// Parameters
//   RSP_DELAY : clocks from CMD stop-bit sample to first response start bit,
//               minus one (legal 1..15)
//   N_DATA    : DATA packets expected ahead of each CMD
//
// Ports
//   clk   : clock, all sampling on posedge
//   rst_n : asynchronous active-low reset
//   sin   : serial request line, idle high
//   sout  : serial response line, idle high, registered
module alu_serial_responder #(
  parameter int RSP_DELAY = 2,
  parameter int N_DATA    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout
);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_BITS,
    CHECK,
    WAIT,
    TX_BITS
  } state_t;

  localparam logic [3:0] NDATA4    = 4'(N_DATA);
  // CHECK itself is the first of the RSP_DELAY silent clocks.
  localparam logic [3:0] WAIT_INIT = (RSP_DELAY >= 2) ? 4'(RSP_DELAY - 2) : 4'd0;
  localparam logic [5:0] RES_BITS  = 6'd55;
  localparam logic [5:0] ERR_BITS  = 6'd11;

  // CRC4, x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4_f(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // CRC3, x^3+x+1, init 0, MSB first
  function automatic logic [2:0] crc3_f(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;     // bit index within a received packet
  logic [8:0]  rx_sh_q, rx_sh_d;   // {type, payload}
  logic [3:0]  dcnt_q, dcnt_d;     // DATA packets since last CMD, saturating
  logic [63:0] opnd_q, opnd_d;     // {B,A}
  logic [2:0]  op_q, op_d;
  logic [3:0]  crc_q, crc_d;       // CRC field received in the CMD
  logic [3:0]  wcnt_q, wcnt_d;
  logic [54:0] tx_q, tx_d;         // outgoing frame, MSB goes out first
  logic [5:0]  txcnt_q, txcnt_d;   // bits left to send
  logic        sout_q, sout_d;

  // ---------------------------------------------------------------------
  // Command evaluation (only consumed in CHECK)
  // ---------------------------------------------------------------------
  logic [31:0] opb, opa, res;
  logic [32:0] sum, diff;
  logic        carry, ovf, zero, neg;
  logic [3:0]  flags;
  logic        err_d, err_c, err_o, err_any;
  logic        op_ok;
  logic [7:0]  err_pl;
  logic [54:0] res_frame, err_frame;

  assign opb  = opnd_q[63:32];
  assign opa  = opnd_q[31:0];
  assign sum  = {1'b0, opb} + {1'b0, opa};
  assign diff = {1'b0, opb} - {1'b0, opa};  // bit 32 is the borrow

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    op_ok = 1'b1;
    case (op_q)
      3'b000: res = opb & opa;
      3'b001: res = opb | opa;
      3'b100: begin
        res   = sum[31:0];
        carry = sum[32];
        ovf   = (opb[31] == opa[31]) && (sum[31] != opb[31]);
      end
      3'b101: begin
        res   = diff[31:0];
        carry = diff[32];
        ovf   = (opb[31] != opa[31]) && (diff[31] != opb[31]);
      end
      default: op_ok = 1'b0;
    endcase
  end

  assign zero  = (res == 32'd0);
  assign neg   = res[31];
  assign flags = {carry, ovf, zero, neg};

  // Error priority: data count, then CRC, then opcode.
  assign err_d   = (dcnt_q != NDATA4);
  assign err_c   = !err_d && (crc_q != crc4_f({opnd_q, 1'b1, op_q}));
  assign err_o   = !err_d && !err_c && !op_ok;
  assign err_any = err_d | err_c | err_o;
  assign err_pl  = {1'b1, err_d, err_c, err_o, err_d, err_c, err_o,
                    ^{1'b1, err_d, err_c, err_o, err_d, err_c, err_o}};

  assign res_frame = {1'b0, 1'b0, res[31:24], 1'b1,
                      1'b0, 1'b0, res[23:16], 1'b1,
                      1'b0, 1'b0, res[15:8],  1'b1,
                      1'b0, 1'b0, res[7:0],   1'b1,
                      1'b0, 1'b1, 1'b0, flags, crc3_f({res, 1'b0, flags}), 1'b1};
  assign err_frame = {1'b0, 1'b1, err_pl, 1'b1, 44'd0};

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rx_sh_d = rx_sh_q;
    dcnt_d  = dcnt_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    crc_d   = crc_q;
    wcnt_d  = wcnt_q;
    tx_d    = tx_q;
    txcnt_d = txcnt_q;
    sout_d  = sout_q;
    case (state_q)
      RX_IDLE: begin
        sout_d = 1'b1;
        if (!sin) begin
          state_d = RX_BITS;
          bcnt_d  = '0;
        end
      end
      RX_BITS: begin
        if (bcnt_q == 4'd9) begin
          // sin is the stop bit; a 0 here drops the packet untouched
          state_d = RX_IDLE;
          if (sin) begin
            if (!rx_sh_q[8]) begin
              opnd_d = {opnd_q[55:0], rx_sh_q[7:0]};
              if (dcnt_q != 4'hF) dcnt_d = dcnt_q + 4'd1;
            end else begin
              op_d    = rx_sh_q[6:4];
              crc_d   = rx_sh_q[3:0];
              state_d = CHECK;
            end
          end
        end else begin
          rx_sh_d = {rx_sh_q[7:0], sin};
          bcnt_d  = bcnt_q + 4'd1;
        end
      end
      CHECK: begin
        dcnt_d  = '0;
        tx_d    = err_any ? err_frame : res_frame;
        txcnt_d = err_any ? ERR_BITS : RES_BITS;
        if (RSP_DELAY >= 2) begin
          state_d = WAIT;
          wcnt_d  = WAIT_INIT;
        end else begin
          state_d = TX_BITS;
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) state_d = TX_BITS;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      TX_BITS: begin
        sout_d  = tx_q[54];
        tx_d    = {tx_q[53:0], 1'b0};
        txcnt_d = txcnt_q - 6'd1;
        // last bit driven is a stop bit, so sout is already idle-high
        if (txcnt_q == 6'd1) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      bcnt_q  <= '0;
      rx_sh_q <= '0;
      dcnt_q  <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      crc_q   <= '0;
      wcnt_q  <= '0;
      tx_q    <= '0;
      txcnt_q <= '0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      rx_sh_q <= rx_sh_d;
      dcnt_q  <= dcnt_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      crc_q   <= crc_d;
      wcnt_q  <= wcnt_d;
      tx_q    <= tx_d;
      txcnt_q <= txcnt_d;
      sout_q  <= sout_d;
    end
  end

  assign sout = sout_q;

endmodule

// File: tb/tb_alu_serial_responder.sv
module tb_alu_serial_responder;

  localparam int RSP_DELAY = 2;
  localparam int N_DATA    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sin   = 1'b1;
  logic sout;

  alu_serial_responder #(.RSP_DELAY(RSP_DELAY), .N_DATA(N_DATA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sin  (sin),
    .sout (sout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [8:0] expq[$];   // expected {type, payload} per response packet
  int  stop_cyc     = 0;
  bit  lat_pending  = 1'b0;

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    bit          crc_bad;
    int          ndata;
    int          bad_idx;   // DATA packet sent with stop=0, -1 for none
    bit          is_err;
    logic [7:0]  err_pl;
    logic [31:0] c;
    logic [3:0]  fl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_crc4(input logic [67:0] d);
    logic [3:0] c = 4'h0;
    logic fb;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

  function automatic logic [2:0] m_crc3(input logic [36:0] d);
    logic [2:0] c = 3'h0;
    logic fb;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ (fb ? 3'h3 : 3'h0);
    end
    return c;
  endfunction

  // Response monitor: decodes packets on sout and pops the scoreboard.
  initial begin
    logic [9:0] pk;
    logic [8:0] e;
    int start_c;
    forever begin
      @(negedge clk);
      if (rst_n && sout === 1'b0) begin
        start_c = cyc;
        if (lat_pending) begin
          chk("latency", 32'(start_c - stop_cyc), 32'(RSP_DELAY + 1));
          lat_pending = 1'b0;
        end
        pk = '0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          pk = {pk[8:0], sout};
        end
        chk("stop_bit", 32'(pk[0]), 32'd1);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet: got %0h expected none", pk[9:1]);
        end else begin
          e = expq.pop_front();
          chk("packet", 32'(pk[9:1]), 32'(e));
        end
      end
    end
  end

  task automatic send_pkt(input bit typ, input logic [7:0] pl, input bit stop, input bit is_cmd);
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = typ;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) sin = pl[i];
    end
    @(negedge clk) sin = stop;
    if (is_cmd) begin
      stop_cyc    = cyc + 1;
      lat_pending = 1'b1;
    end
    @(negedge clk) sin = 1'b1;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (expq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d packets outstanding expected 0", expq.size());
      expq.delete();
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] ba;
    logic [3:0]  crc;
    logic [7:0]  byt;
    int k;
    ba  = {v.b, v.a};
    crc = m_crc4({ba, 1'b1, v.op}) ^ (v.crc_bad ? 4'hF : 4'h0);
    for (int i = 0; i < v.ndata; i++) begin
      k = i - (v.ndata - 8);
      if (k < 0) byt = 8'h5A;
      else       byt = ba[63 - 8*k -: 8];
      send_pkt(1'b0, byt, (i == v.bad_idx) ? 1'b0 : 1'b1, 1'b0);
    end
    if (v.is_err) begin
      expq.push_back({1'b1, v.err_pl});
    end else begin
      expq.push_back({1'b0, v.c[31:24]});
      expq.push_back({1'b0, v.c[23:16]});
      expq.push_back({1'b0, v.c[15:8]});
      expq.push_back({1'b0, v.c[7:0]});
      expq.push_back({1'b1, 1'b0, v.fl, m_crc3({v.c, 1'b0, v.fl})});
    end
    send_pkt(1'b1, {1'b0, v.op, crc}, 1'b1, 1'b1);
    wait_rsp();
  endtask

  vec_t tv[13];

  initial begin
    //               b             a             op      bad nd bi  err pl     c             fl
    tv[0]  = '{32'h00000003, 32'h00000002, 3'b100, 1'b0, 8, -1, 1'b0, 8'h00, 32'h00000005, 4'b0000};
    tv[1]  = '{32'h00000001, 32'hFFFFFFFF, 3'b100, 1'b0, 8, -1, 1'b0, 8'h00, 32'h00000000, 4'b1010};
    tv[2]  = '{32'h00000005, 32'h00000007, 3'b101, 1'b0, 8, -1, 1'b0, 8'h00, 32'hFFFFFFFE, 4'b1001};
    tv[3]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 1'b0, 8, -1, 1'b0, 8'h00, 32'h00F000F0, 4'b0000};
    tv[4]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 1'b0, 8, -1, 1'b0, 8'h00, 32'hFFF0FFF0, 4'b0001};
    tv[5]  = '{32'h12345678, 32'h9ABCDEF0, 3'b100, 1'b1, 8, -1, 1'b1, 8'hA5, 32'h0,        4'b0000};
    tv[6]  = '{32'h00000010, 32'h00000020, 3'b110, 1'b0, 8, -1, 1'b1, 8'h93, 32'h0,        4'b0000};
    tv[7]  = '{32'h00000010, 32'h00000020, 3'b010, 1'b0, 8, -1, 1'b1, 8'h93, 32'h0,        4'b0000};
    tv[8]  = '{32'h00000003, 32'h00000002, 3'b100, 1'b0, 6, -1, 1'b1, 8'hC9, 32'h0,        4'b0000};
    tv[9]  = '{32'h00000003, 32'h00000002, 3'b100, 1'b0, 9, -1, 1'b1, 8'hC9, 32'h0,        4'b0000};
    tv[10] = '{32'h80000000, 32'h00000001, 3'b101, 1'b0, 8, -1, 1'b0, 8'h00, 32'h7FFFFFFF, 4'b0100};
    tv[11] = '{32'h00000003, 32'h00000002, 3'b100, 1'b0, 8,  3, 1'b1, 8'hC9, 32'h0,        4'b0000};
    tv[12] = '{32'h7FFFFFFF, 32'h00000001, 3'b100, 1'b0, 8, -1, 1'b0, 8'h00, 32'h80000000, 4'b0101};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_sout", 32'(sout), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // reset in the middle of the 5th DATA packet
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'hC3, 1'b1, 1'b0);
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = 1'b1;
    @(negedge clk) sin = 1'b1;
    @(negedge clk) begin rst_n = 1'b0; sin = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sout_in_reset", 32'(sout), 32'd1);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("sout_after_reset", 32'(sout), 32'd1);

    for (int t = 0; t < 13; t++) run_vec(tv[t]);

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
